// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample RAM, masked level/edge trigger with
// programmable pre-trigger depth, and a chronological readout port for a debug bridge.
module la_capture_core #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned TRIG_W = 2,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_mask,
  input  logic [TRIG_W-1:0] trig_value,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pretrig,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, trig_ptr_q, pre_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] post_len, oldest, rd_ptr;
  logic              triggered_q, match_d_q, rd_have_q, rd_valid_q;
  logic              match, hit, wr_en, rd_fire, arm_go, trig_now;
  logic [DATA_W-1:0] rd_raw_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Trigger evaluation; match_d tracks the previous cycle's match for edge mode.
  always_comb begin
    match    = (((trig_i ^ trig_value) & trig_mask) == '0);
    hit      = trig_edge ? (match & ~match_d_q) : match;
    busy     = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    done     = (state_q == StDone);
    wr_en    = busy;
    arm_go   = arm & ~abort & ((state_q == StIdle) || (state_q == StDone));
    // Samples still to be written after the trigger sample.
    post_len = ADDR_W'(DEPTH - 1) - pre_q;
    oldest   = trig_ptr_q - pre_q;
    rd_ptr   = oldest + rd_addr;
    rd_fire  = rd_en & done;
  end

  // Next-state logic for the capture sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trig_now = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d = (pretrig == '0) ? StWait : StPre;
          cnt_d   = '0;
        end
      end
      StPre: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == pre_q - ADDR_W'(1)) state_d = StWait;
      end
      StWait: begin
        if (hit) begin
          trig_now = 1'b1;
          cnt_d    = '0;
          state_d  = (post_len == '0) ? StDone : StPost;
        end
      end
      StPost: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == post_len - ADDR_W'(1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Control and status registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      pre_q       <= '0;
      triggered_q <= 1'b0;
      match_d_q   <= 1'b0;
      rd_have_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      match_d_q  <= match;
      rd_valid_q <= rd_fire;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      // Pre-trigger depth is frozen at arm so the readout origin stays consistent.
      if (arm_go) pre_q <= pretrig;
      if (trig_now && !abort) trig_ptr_q <= wr_ptr_q;
      if (abort || arm_go) triggered_q <= 1'b0;
      else if (trig_now)   triggered_q <= 1'b1;
      if (rd_fire) rd_have_q <= 1'b1;
    end
  end

  // Sample RAM: one write port, one registered read port, no reset so it maps to block RAM.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
    if (rd_fire) rd_raw_q <= mem[rd_ptr];
  end

  // rd_data reads as zero until the first read after reset, then holds the last result.
  always_comb begin
    triggered = triggered_q;
    rd_valid  = rd_valid_q;
    rd_data   = rd_have_q ? rd_raw_q : '0;
  end

endmodule
